// File: rtl/decode_stage_pkg.sv
// Y86 decode stage shared types and constants.
// Icode encodings, register IDs, E-register bundle and ID decode helpers.
package decode_stage_pkg;

  localparam int NIBBLE = 4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IIRMOVL = 4'h3;
  localparam logic [3:0] IRMMOVL = 4'h4;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHL  = 4'hA;
  localparam logic [3:0] IPOPL   = 4'hB;

  localparam logic [3:0] RESP    = 4'h4;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] FNONE   = 4'h0;

  typedef struct packed {
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] srcA;
    logic [3:0] srcB;
    logic [3:0] dstE;
    logic [3:0] dstM;
  } id_ex_t;

  localparam id_ex_t ID_BUBBLE = '{
    icode: INOP,  ifun: FNONE,
    srcA:  RNONE, srcB: RNONE,
    dstE:  RNONE, dstM: RNONE
  };

  function automatic logic [3:0] get_srcA(
    input logic [3:0] icode,
    input logic [3:0] ra
  );
    logic [3:0] id;
    id = RNONE;
    unique case (1'b1)
      (icode inside {IRRMOVL, IRMMOVL, IOPL, IPUSHL}): id = ra;
      (icode inside {IPOPL, IRET}):                    id = RESP;
      default:                                         id = RNONE;
    endcase
    return id;
  endfunction

  function automatic logic [3:0] get_srcB(
    input logic [3:0] icode,
    input logic [3:0] rb
  );
    logic [3:0] id;
    id = RNONE;
    unique case (1'b1)
      (icode inside {IOPL, IRMMOVL, IMRMOVL}):       id = rb;
      (icode inside {IPUSHL, IPOPL, ICALL, IRET}):   id = RESP;
      default:                                       id = RNONE;
    endcase
    return id;
  endfunction

  function automatic logic [3:0] get_dstE(
    input logic [3:0] icode,
    input logic [3:0] rb
  );
    logic [3:0] id;
    id = RNONE;
    unique case (1'b1)
      (icode inside {IRRMOVL, IIRMOVL, IOPL}):       id = rb;
      (icode inside {IPUSHL, IPOPL, ICALL, IRET}):   id = RESP;
      default:                                       id = RNONE;
    endcase
    return id;
  endfunction

  function automatic logic [3:0] get_dstM(
    input logic [3:0] icode,
    input logic [3:0] ra
  );
    logic [3:0] id;
    id = RNONE;
    unique case (1'b1)
      (icode inside {IMRMOVL, IPOPL}): id = ra;
      default:                         id = RNONE;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/decode_stage_fwd_select.sv
// Operand select: optional valP, RNONE zeroing, then E/M/W forwarding.
// Priority is fixed; m_valM beats M_valE when both target the same ID.
module fwd_select
  import decode_stage_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter bit USE_VALP = 1'b0
) (
  input  logic [3:0]        i_src,
  input  logic              i_sel_valp,
  input  logic [WORD_W-1:0] i_valp,
  input  logic [WORD_W-1:0] i_rval,
  input  logic [3:0]        i_e_dstE,
  input  logic [WORD_W-1:0] i_e_valE,
  input  logic [3:0]        i_M_dstM,
  input  logic [WORD_W-1:0] i_m_valM,
  input  logic [3:0]        i_M_dstE,
  input  logic [WORD_W-1:0] i_M_valE,
  input  logic [3:0]        i_W_dstM,
  input  logic [WORD_W-1:0] i_W_valM,
  input  logic [3:0]        i_W_dstE,
  input  logic [WORD_W-1:0] i_W_valE,
  output logic [WORD_W-1:0] o_val
);

  // RNONE source returns 0 before any compare, so RNONE dsts never match
  always_comb begin
    o_val = i_rval;
    if (USE_VALP && i_sel_valp)
      o_val = i_valp;
    else if (i_src == RNONE)
      o_val = '0;
    else if (i_src == i_e_dstE)
      o_val = i_e_valE;
    else if (i_src == i_M_dstM)
      o_val = i_m_valM;
    else if (i_src == i_M_dstE)
      o_val = i_M_valE;
    else if (i_src == i_W_dstM)
      o_val = i_W_valM;
    else if (i_src == i_W_dstE)
      o_val = i_W_valE;
    else
      o_val = i_rval;
  end

endmodule

// File: rtl/decode_stage.sv
// Y86 decode/forward stage: register IDs, forwarded operands
// and the E pipeline register with stall/bubble control.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              E_stall,
  input  logic              E_bubble,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [WORD_W-1:0] D_valC,
  input  logic [WORD_W-1:0] D_valP,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  input  logic [WORD_W-1:0] rvalA,
  input  logic [WORD_W-1:0] rvalB,
  input  logic [3:0]        e_dstE,
  input  logic [WORD_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic [WORD_W-1:0] M_valE,
  input  logic [WORD_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  input  logic [WORD_W-1:0] W_valE,
  input  logic [WORD_W-1:0] W_valM,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [WORD_W-1:0] E_valA,
  output logic [WORD_W-1:0] E_valB,
  output logic [WORD_W-1:0] E_valC
);

  id_ex_t            w_dec;
  logic              w_sel_valp;
  logic [WORD_W-1:0] w_valA;
  logic [WORD_W-1:0] w_valB;

  id_ex_t            r_e;
  logic [WORD_W-1:0] r_valA;
  logic [WORD_W-1:0] r_valB;
  logic [WORD_W-1:0] r_valC;

  always_comb begin
    w_dec       = ID_BUBBLE;
    w_dec.icode = D_icode;
    w_dec.ifun  = D_ifun;
    w_dec.srcA  = get_srcA(D_icode, D_rA);
    w_dec.srcB  = get_srcB(D_icode, D_rB);
    w_dec.dstE  = get_dstE(D_icode, D_rB);
    w_dec.dstM  = get_dstM(D_icode, D_rA);
  end

  assign w_sel_valp = (D_icode == ICALL) || (D_icode == IJXX);
  assign srcA       = w_dec.srcA;
  assign srcB       = w_dec.srcB;

  fwd_select #(.WORD_W(WORD_W), .USE_VALP(1'b1)) u_fwd_a (
    .i_src      (w_dec.srcA),
    .i_sel_valp (w_sel_valp),
    .i_valp     (D_valP),
    .i_rval     (rvalA),
    .i_e_dstE   (e_dstE),
    .i_e_valE   (e_valE),
    .i_M_dstM   (M_dstM),
    .i_m_valM   (m_valM),
    .i_M_dstE   (M_dstE),
    .i_M_valE   (M_valE),
    .i_W_dstM   (W_dstM),
    .i_W_valM   (W_valM),
    .i_W_dstE   (W_dstE),
    .i_W_valE   (W_valE),
    .o_val      (w_valA)
  );

  fwd_select #(.WORD_W(WORD_W), .USE_VALP(1'b0)) u_fwd_b (
    .i_src      (w_dec.srcB),
    .i_sel_valp (1'b0),
    .i_valp     (D_valP),
    .i_rval     (rvalB),
    .i_e_dstE   (e_dstE),
    .i_e_valE   (e_valE),
    .i_M_dstM   (M_dstM),
    .i_m_valM   (m_valM),
    .i_M_dstE   (M_dstE),
    .i_M_valE   (M_valE),
    .i_W_dstM   (W_dstM),
    .i_W_valM   (W_valM),
    .i_W_dstE   (W_dstE),
    .i_W_valE   (W_valE),
    .o_val      (w_valB)
  );

  // Bubble beats stall; reset loads the bubble asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e    <= ID_BUBBLE;
      r_valA <= '0;
      r_valB <= '0;
      r_valC <= '0;
    end else if (E_bubble) begin
      r_e    <= ID_BUBBLE;
      r_valA <= '0;
      r_valB <= '0;
      r_valC <= '0;
    end else if (!E_stall) begin
      r_e    <= w_dec;
      r_valA <= w_valA;
      r_valB <= w_valB;
      r_valC <= D_valC;
    end
  end

  assign E_icode = r_e.icode;
  assign E_ifun  = r_e.ifun;
  assign E_srcA  = r_e.srcA;
  assign E_srcB  = r_e.srcB;
  assign E_dstE  = r_e.dstE;
  assign E_dstM  = r_e.dstM;
  assign E_valA  = r_valA;
  assign E_valB  = r_valB;
  assign E_valC  = r_valC;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus
// randomized traffic against a table-driven reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        E_stall, E_bubble;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [31:0] D_valC, D_valP;
  logic [3:0]  srcA, srcB;
  logic [31:0] rvalA, rvalB;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [31:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
  logic [31:0] E_valA, E_valB, E_valC;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0]  icode, ifun, sa, sb, de, dm;
    logic [31:0] va, vb, vc;
  } rec_t;

  localparam rec_t BUB = '{icode:4'h1, ifun:4'h0, sa:4'hF, sb:4'hF,
                           de:4'hF, dm:4'hF, va:32'h0, vb:32'h0, vc:32'h0};

  always #5 clk = ~clk;

  decode_stage #(.WORD_W(32)) dut (
    .clk(clk), .rst(rst), .E_stall(E_stall), .E_bubble(E_bubble),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .srcA(srcA), .srcB(srcB),
    .rvalA(rvalA), .rvalB(rvalB), .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_valA(E_valA), .E_valB(E_valB),
    .E_valC(E_valC)
  );

  function automatic rec_t act();
    return '{icode:E_icode, ifun:E_ifun, sa:E_srcA, sb:E_srcB, de:E_dstE,
             dm:E_dstM, va:E_valA, vb:E_valB, vc:E_valC};
  endfunction

  // Reference: rule tables straight from the instruction set
  function automatic logic [31:0] m_fwd(input logic [3:0] s,
                                        input logic [31:0] rv);
    logic [3:0]  d[5];
    logic [31:0] v[5];
    d = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    v = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (s == 4'hF) return 32'h0;
    for (int k = 0; k < 5; k++)
      if (d[k] == s) return v[k];
    return rv;
  endfunction

  function automatic rec_t model();
    rec_t r;
    logic [3:0] ic;
    ic = D_icode;
    r = BUB;
    r.icode = ic;
    r.ifun  = D_ifun;
    r.vc    = D_valC;
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) r.sa = D_rA;
    else if (ic inside {4'hB, 4'h9})        r.sa = 4'h4;
    if (ic inside {4'h6, 4'h4, 4'h5})             r.sb = D_rB;
    else if (ic inside {4'hA, 4'hB, 4'h8, 4'h9})  r.sb = 4'h4;
    if (ic inside {4'h2, 4'h3, 4'h6})             r.de = D_rB;
    else if (ic inside {4'hA, 4'hB, 4'h8, 4'h9})  r.de = 4'h4;
    if (ic inside {4'h5, 4'hB}) r.dm = D_rA;
    r.va = (ic inside {4'h8, 4'h7}) ? D_valP : m_fwd(r.sa, rvalA);
    r.vb = m_fwd(r.sb, rvalB);
    return r;
  endfunction

  task automatic idle_fwd();
    E_stall = 0; E_bubble = 0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF;
    W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    rvalA = 0; rvalB = 0;
    D_ifun = 0; D_valC = 0; D_valP = 0;
  endtask

  task automatic rand_inputs();
    D_icode = 4'($urandom); D_ifun = 4'($urandom);
    D_rA = 4'($urandom); D_rB = 4'($urandom);
    D_valC = $urandom; D_valP = $urandom;
    rvalA = $urandom; rvalB = $urandom;
    e_dstE = 4'($urandom_range(0, 6)); M_dstE = 4'($urandom_range(0, 6));
    M_dstM = 4'($urandom_range(0, 6)); W_dstE = 4'($urandom_range(0, 6));
    W_dstM = 4'($urandom_range(0, 6));
    if (e_dstE == 6) e_dstE = 4'hF;
    if (M_dstM == 6) M_dstM = 4'hF;
    if (W_dstM == 6) W_dstM = 4'hF;
    e_valE = $urandom; M_valE = $urandom; m_valM = $urandom;
    W_valE = $urandom; W_valM = $urandom;
  endtask

  task automatic test_reset();
    rst = 0; E_stall = 0; E_bubble = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_inputs();
      #1;
      n_chk++;
      if (act() !== BUB) begin
        n_fail++;
        $display("FAIL reset_hold: got %h want %h", act(), BUB);
      end
    end
    @(negedge clk);
    idle_fwd();
    D_icode = 4'h3; D_rA = 4'hF; D_rB = 4'h2; D_valC = 32'h10;
    rst = 1;
    #1;
    n_chk++;
    if (E_icode !== 4'h1) begin
      n_fail++;
      $display("FAIL reset_release_early: E_icode got %h want 1", E_icode);
    end
    @(posedge clk); #1;
    n_chk++;
    if (E_dstE !== 4'h2 || E_valC !== 32'h10) begin
      n_fail++;
      $display("FAIL reset_first_load: dstE %h valC %h want 2 10",
               E_dstE, E_valC);
    end
  endtask

  task automatic test_opl();
    @(negedge clk);
    idle_fwd();
    D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h3;
    e_dstE = 4'h1; e_valE = 32'hAA; M_dstE = 4'h3; M_valE = 32'hBB;
    rvalA = 32'h1111; rvalB = 32'h2222;
    #1;
    n_chk++;
    if (srcA !== 4'h1 || srcB !== 4'h3) begin
      n_fail++;
      $display("FAIL opl_src: got %h %h want 1 3", srcA, srcB);
    end
    @(posedge clk); #1;
    n_chk++;
    if (E_valA !== 32'hAA || E_valB !== 32'hBB) begin
      n_fail++;
      $display("FAIL opl_vals: got %h %h want aa bb", E_valA, E_valB);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    idle_fwd();
    D_icode = 4'h2; D_rA = 4'h5; D_rB = 4'h0;
    M_dstM = 4'h5; m_valM = 32'h11;
    M_dstE = 4'h5; M_valE = 32'h22;
    W_dstE = 4'h5; W_valE = 32'h33;
    @(posedge clk); #1;
    n_chk++;
    if (E_valA !== 32'h11) begin
      n_fail++;
      $display("FAIL prio_mvalm: got %h want 11", E_valA);
    end
    @(negedge clk);
    M_dstM = 4'hF; W_dstM = 4'h5; W_valM = 32'h44;
    @(posedge clk); #1;
    n_chk++;
    if (E_valA !== 32'h22) begin
      n_fail++;
      $display("FAIL prio_mvale: got %h want 22", E_valA);
    end
    @(negedge clk);
    M_dstE = 4'hF;
    @(posedge clk); #1;
    n_chk++;
    if (E_valA !== 32'h44) begin
      n_fail++;
      $display("FAIL prio_wvalm: got %h want 44", E_valA);
    end
  endtask

  task automatic test_call();
    @(negedge clk);
    idle_fwd();
    D_icode = 4'h8; D_rA = 4'h4; D_rB = 4'h4; D_valP = 32'h40;
    e_dstE = 4'hF; W_dstE = 4'h4; W_valE = 32'h99; rvalA = 32'h77;
    #1;
    n_chk++;
    if (srcB !== 4'h4 || srcA !== 4'hF) begin
      n_fail++;
      $display("FAIL call_src: got %h %h want f 4", srcA, srcB);
    end
    @(posedge clk); #1;
    n_chk++;
    if (E_valA !== 32'h40 || E_dstE !== 4'h4 || E_valB !== 32'h99) begin
      n_fail++;
      $display("FAIL call_e: valA %h dstE %h valB %h want 40 4 99",
               E_valA, E_dstE, E_valB);
    end
  endtask

  task automatic test_irmovl();
    @(negedge clk);
    idle_fwd();
    D_icode = 4'h3; D_rA = 4'hF; D_rB = 4'h6; D_valC = 32'h1234;
    rvalA = 32'hDEAD;
    @(posedge clk); #1;
    n_chk++;
    if (E_valA !== 32'h0 || E_srcA !== 4'hF || E_dstE !== 4'h6) begin
      n_fail++;
      $display("FAIL irmovl: valA %h srcA %h dstE %h want 0 f 6",
               E_valA, E_srcA, E_dstE);
    end
  endtask

  task automatic test_stall();
    rec_t held;
    @(negedge clk);
    rand_inputs();
    D_icode = 4'h6;
    E_stall = 0; E_bubble = 0;
    held = model();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rand_inputs();
      E_stall = 1;
      @(posedge clk); #1;
      n_chk++;
      if (act() !== held) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %h want %h", i, act(), held);
      end
    end
    @(negedge clk);
    E_bubble = 1;
    @(posedge clk); #1;
    n_chk++;
    if (act() !== BUB) begin
      n_fail++;
      $display("FAIL stall_bubble: got %h want %h", act(), BUB);
    end
    @(negedge clk);
    E_bubble = 0; E_stall = 0;
    D_icode = 4'hB;
    held = model();
    @(posedge clk); #2;
    E_stall = 1;
    rst = 0;
    #1;
    n_chk++;
    if (act() !== BUB) begin
      n_fail++;
      $display("FAIL async_reset_stall: got %h want %h", act(), BUB);
    end
    @(negedge clk);
    rst = 1; E_stall = 0;
  endtask

  task automatic test_random();
    rec_t exp_e, dec;
    exp_e = BUB;
    @(negedge clk);
    rst = 0; #1; rst = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rand_inputs();
      E_stall  = ($urandom_range(0, 7) == 0);
      E_bubble = ($urandom_range(0, 9) == 0);
      #1;
      dec = model();
      n_chk++;
      if (srcA !== dec.sa || srcB !== dec.sb) begin
        n_fail++;
        $display("FAIL rand_src%0d: got %h %h want %h %h",
                 i, srcA, srcB, dec.sa, dec.sb);
      end
      if (E_bubble)     exp_e = BUB;
      else if (!E_stall) exp_e = dec;
      @(posedge clk); #1;
      n_chk++;
      if (act() !== exp_e) begin
        n_fail++;
        $display("FAIL rand_e%0d: got %h want %h", i, act(), exp_e);
      end
    end
  endtask

  initial begin
    rst = 0;
    idle_fwd();
    D_icode = 0; D_rA = 4'hF; D_rB = 4'hF;
    test_reset();
    test_opl();
    test_priority();
    test_call();
    test_irmovl();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
